seq_vector_sequencer: RTL and testbench

Programmable stimulus sequencer that drives the A/B inputs of the `sequentialDemo` datapath. It plays a stored list of 2-bit {A,B} vectors, one vector per hold window, and records Z at the end of each window into a result log. It sits between a host/control port and the datapath, giving start/busy/done sequencing so vector lists no longer need hand-written delays.

---
 rtl/seq_vector_sequencer_if.sv | 26 ++
 rtl/seq_vector_sequencer.sv | 135 +++++++++++++
 tb/tb_seq_vector_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seq_vector_sequencer_if.sv
// Host/datapath-facing signal bundle for the vector sequencer.
// The slave modport is the sequencer's view; the master modport is the host/bench view.
interface seq_vector_sequencer_if;
    logic       WR_EN;
    logic [2:0] WR_ADDR;
    logic [1:0] WR_DATA;
    logic [3:0] LEN;
    logic       START;
    logic       ABORT;
    logic       BUSY;
    logic       DONE;
    logic       A_OUT;
    logic       B_OUT;
    logic       Z_IN;
    logic [7:0] Z_LOG;

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA, LEN, START, ABORT, Z_IN,
        output BUSY, DONE, A_OUT, B_OUT, Z_LOG
    );

    modport master (
        output WR_EN, WR_ADDR, WR_DATA, LEN, START, ABORT, Z_IN,
        input  BUSY, DONE, A_OUT, B_OUT, Z_LOG
    );
endinterface

// File: rtl/seq_vector_sequencer.sv
// Plays a stored list of {A,B} vectors, each held for HOLD cycles, and logs Z at
// the last edge of every hold window. All outputs come straight from registers.
module seq_vector_sequencer #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    seq_vector_sequencer_if.slave       bus
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      mem_q [DEPTH];
    logic [2:0]      idx_q, idx_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [3:0]      len_q, len_d;
    logic [7:0]      zlog_q, zlog_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            a_q, a_d;
    logic            b_q, b_d;

    logic [3:0]      len_clamp;
    logic            wr_ok;
    logic            last_vec;

    assign len_clamp = (bus.LEN > 4'd8) ? 4'd8 : bus.LEN;
    assign wr_ok     = bus.WR_EN && (state_q != S_RUN);
    assign last_vec  = ({1'b0, idx_q} == (len_q - 4'd1));

    // NOTE: the vector store must read back as zero after reset, so it is reset
    // slot by slot like any other register rather than left as uninitialised RAM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else if (wr_ok) begin
            mem_q[bus.WR_ADDR] <= bus.WR_DATA;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        hcnt_d  = hcnt_q;
        len_d   = len_q;
        zlog_d  = zlog_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    zlog_d  = 8'h00;
                    len_d   = len_clamp;
                    idx_d   = 3'd0;
                    hcnt_d  = '0;
                    state_d = (len_clamp == 4'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.ABORT) begin
                    // A capture falling on the abort edge is dropped on purpose.
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                    hcnt_d  = '0;
                end else if (hcnt_q == HW'(HOLD - 1)) begin
                    zlog_d[idx_q] = bus.Z_IN;
                    hcnt_d        = '0;
                    if (last_vec) begin
                        state_d = S_DONE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered yet aligned.
        busy_d     = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        {a_d, b_d} = busy_d ? mem_q[idx_d] : 2'b00;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            hcnt_q  <= '0;
            len_q   <= 4'd0;
            zlog_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hcnt_q  <= hcnt_d;
            len_q   <= len_d;
            zlog_q  <= zlog_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.A_OUT = a_q;
    assign bus.B_OUT = b_q;
    assign bus.Z_LOG = zlog_q;

endmodule

// File: tb/tb_seq_vector_sequencer.sv
// Self-checking bench for seq_vector_sequencer: directed scenarios plus randomized
// runs, each compared cycle by cycle against a vector-list model of playback.
module tb_seq_vector_sequencer;

    localparam int HOLD = 2;

    logic clk;
    logic rst_n;
    logic loop_mode;
    logic z_drv;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] ref_mem [8];

    seq_vector_sequencer_if bus ();

    seq_vector_sequencer #(.DEPTH(8), .HOLD(HOLD)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    assign bus.Z_IN = loop_mode ? (bus.A_OUT ^ bus.B_OUT) : z_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_slot(input int addr, input logic [1:0] data);
        @(negedge clk);
        bus.WR_EN   = 1'b1;
        bus.WR_ADDR = addr[2:0];
        bus.WR_DATA = data;
        @(negedge clk);
        bus.WR_EN   = 1'b0;
        ref_mem[addr] = data;
    endtask

    // zmode: 0 = random Z per cycle, 1 = loopback A^B, 2 = Z tied high.
    // abort_at / intrude_at are cycle numbers after START, or -1 for none.
    task automatic play(input string tag, input int len, input int zmode,
                        input int abort_at, input int intrude_at,
                        output logic [7:0] exp_z);
        int          l;
        int          n;
        bit          aborted;
        bit          zpat [64];
        logic [3:0]  exp_v;

        l = (len > 8) ? 8 : len;
        n = l * HOLD;
        for (int k = 0; k < 64; k++) zpat[k] = (zmode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        exp_z   = 8'h00;
        aborted = 1'b0;

        @(negedge clk);
        loop_mode = (zmode == 1);
        z_drv     = zpat[0];
        bus.LEN   = len[3:0];
        bus.START = 1'b1;
        bus.ABORT = 1'($urandom_range(0, 1));  // START must win over ABORT in IDLE
        @(posedge clk);

        for (int k = 0; k < n + 3; k++) begin
            @(negedge clk);
            bus.START = 1'b0;
            bus.ABORT = 1'b0;
            bus.WR_EN = 1'b0;
            if (k == 0) check($sformatf("%s zlog_clear", tag), 32'(bus.Z_LOG), 32'h0);

            if (aborted)       exp_v = 4'b0000;
            else if (k < n)    exp_v = {2'b10, ref_mem[k / HOLD]};
            else if (k == n)   exp_v = 4'b0100;
            else               exp_v = 4'b0000;
            check($sformatf("%s cyc%0d busy_done_a_b", tag, k),
                  32'({bus.BUSY, bus.DONE, bus.A_OUT, bus.B_OUT}), 32'(exp_v));

            z_drv = zpat[k];
            if (!aborted && k < n) begin
                if (k == abort_at) begin
                    bus.ABORT = 1'b1;
                end else if ((k % HOLD) == HOLD - 1) begin
                    exp_z[k / HOLD] = (zmode == 1) ? ^ref_mem[k / HOLD] : zpat[k];
                end
                if (k == intrude_at) begin
                    bus.WR_EN   = 1'b1;
                    bus.WR_ADDR = 3'd0;
                    bus.WR_DATA = 2'b11;
                    bus.START   = 1'b1;
                end
            end
            if (k == abort_at) aborted = 1'b1;
        end

        @(negedge clk);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.WR_EN = 1'b0;
        check($sformatf("%s zlog", tag), 32'(bus.Z_LOG), 32'(exp_z));
        check($sformatf("%s idle_outs", tag),
              32'({bus.BUSY, bus.DONE, bus.A_OUT, bus.B_OUT}), 32'h0);
    endtask

    logic [7:0] ez;

    initial begin
        bus.WR_EN   = 1'b0;
        bus.WR_ADDR = 3'd0;
        bus.WR_DATA = 2'b00;
        bus.LEN     = 4'd0;
        bus.START   = 1'b0;
        bus.ABORT   = 1'b0;
        loop_mode   = 1'b0;
        z_drv       = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 2'b00;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'({bus.BUSY, bus.DONE, bus.A_OUT, bus.B_OUT, bus.Z_LOG}), 32'h0);
        rst_n = 1'b1;

        // Full pattern with loopback
        write_slot(0, 2'b00); write_slot(1, 2'b11); write_slot(2, 2'b01); write_slot(3, 2'b00);
        write_slot(4, 2'b11); write_slot(5, 2'b10); write_slot(6, 2'b01); write_slot(7, 2'b10);
        play("full", 8, 1, -1, -1, ez);
        check("full_e4", 32'(bus.Z_LOG), 32'hE4);

        play("partial", 3, 2, -1, -1, ez);
        check("partial_07", 32'(bus.Z_LOG), 32'h07);

        play("zero", 0, 2, -1, -1, ez);
        check("zero_zlog", 32'(bus.Z_LOG), 32'h00);
        play("clamp", 12, 1, -1, -1, ez);
        check("clamp_e4", 32'(bus.Z_LOG), 32'hE4);

        play("abort", 8, 1, 5, -1, ez);
        check("abort_zlog", 32'(bus.Z_LOG), 32'h00);
        play("rerun", 8, 1, -1, -1, ez);
        check("rerun_e4", 32'(bus.Z_LOG), 32'hE4);

        // Write and START during RUN are both ignored; slot 0 must still hold 00
        play("intrude", 8, 1, -1, 3, ez);
        check("intrude_e4", 32'(bus.Z_LOG), 32'hE4);
        play("slot0_kept", 1, 2, -1, -1, ez);

        // Asynchronous reset between edges, mid-run
        @(negedge clk);
        loop_mode = 1'b0;
        z_drv     = 1'b1;
        bus.LEN   = 4'd8;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(bus.BUSY), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'({bus.BUSY, bus.DONE, bus.A_OUT, bus.B_OUT, bus.Z_LOG}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) ref_mem[i] = 2'b00;
        play("post_rst", 8, 2, -1, -1, ez);
        check("post_rst_ff", 32'(bus.Z_LOG), 32'hFF);

        // Randomized runs
        for (int r = 0; r < 24; r++) begin
            int nw, len, zm, ab, it, n;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) write_slot($urandom_range(0, 7), 2'($urandom_range(0, 3)));
            len = $urandom_range(0, 12);
            zm  = $urandom_range(0, 1);
            n   = ((len > 8) ? 8 : len) * HOLD;
            ab  = -1;
            it  = -1;
            if (n > 0 && $urandom_range(0, 3) == 0)      ab = $urandom_range(0, n - 1);
            else if (n > 2 && $urandom_range(0, 3) == 0) it = $urandom_range(0, n - 2);
            play($sformatf("rnd%0d", r), len, zm, ab, it, ez);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
